// File: rtl/mac_operand_feeder_if.sv
//==============================================================================
// Module      : mac_operand_feeder_if
// Description : Operand stream, MAC vector bus and result stream of the
//               operand feeder. Optional in_last under MAC_FEED_LAST_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface mac_operand_feeder_if #(
    parameter int N_PAIRS = 12,
    parameter int DW      = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic [DW-1:0]           in_a;
    logic [DW-1:0]           in_b;
`ifdef MAC_FEED_LAST_EN
    logic                    in_last;
`endif
    logic [N_PAIRS*DW-1:0]   a_vec;
    logic [N_PAIRS*DW-1:0]   b_vec;
    logic                    mac_start;
    logic [DW-1:0]           mac_result;
    logic                    res_valid;
    logic                    res_ready;
    logic [DW-1:0]           res_data;

`ifdef MAC_FEED_LAST_EN
    // Feeder side
    modport slave (
        input  in_valid, in_a, in_b, in_last, mac_result, res_ready,
        output in_ready, a_vec, b_vec, mac_start, res_valid, res_data
    );
    // Operand source / MAC / result consumer side
    modport master (
        output in_valid, in_a, in_b, in_last, mac_result, res_ready,
        input  in_ready, a_vec, b_vec, mac_start, res_valid, res_data
    );
`else
    modport slave (
        input  in_valid, in_a, in_b, mac_result, res_ready,
        output in_ready, a_vec, b_vec, mac_start, res_valid, res_data
    );
    modport master (
        output in_valid, in_a, in_b, mac_result, res_ready,
        input  in_ready, a_vec, b_vec, mac_start, res_valid, res_data
    );
`endif

endinterface

`default_nettype wire

// File: rtl/mac_operand_feeder.sv
//==============================================================================
// Module      : mac_operand_feeder
// Description : Packs serial (A,B) operand pairs into the MAC's parallel lane
//               buses, issues the MAC, waits its fixed latency and returns
//               the dot product on a valid/ready result stream.
//               Optional macro MAC_FEED_LAST_EN: early vector end via in_last.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mac_operand_feeder #(
    parameter int N_PAIRS     = 12,
    parameter int DW          = 16,
    parameter int MAC_LATENCY = 4
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    mac_operand_feeder_if.slave    bus,
    output logic                   busy
);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    localparam int c_CNT_W  = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;
    localparam int c_WAIT_W = $clog2(MAC_LATENCY + 1);
    localparam logic [c_CNT_W-1:0]  c_LAST_LANE = c_CNT_W'(N_PAIRS - 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LOAD = c_WAIT_W'(MAC_LATENCY - 1);

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [c_CNT_W-1:0]            r_cnt;
    logic [c_CNT_W-1:0]            w_cnt_nxt;
    logic [c_WAIT_W-1:0]           r_wait;
    logic [c_WAIT_W-1:0]           w_wait_nxt;
    logic                          r_res_valid;
    logic                          w_res_valid_nxt;
    logic [DW-1:0]                 r_res_data;
    logic [DW-1:0]                 w_res_data_nxt;
    logic [N_PAIRS-1:0][DW-1:0]    r_a_lane;
    logic [N_PAIRS-1:0][DW-1:0]    r_b_lane;

    logic                          w_in_ready;
    logic                          w_xfer;
    logic                          w_early;
    logic                          w_done;

    // in_ready is held low while reset is asserted, then follows the FILL state
    assign w_in_ready = rst_n & (r_state == S_FILL);
    assign w_xfer     = bus.in_valid & w_in_ready;

`ifdef MAC_FEED_LAST_EN
    assign w_early = bus.in_last & (r_cnt != c_LAST_LANE);
`else
    assign w_early = 1'b0;
`endif
    assign w_done = (r_cnt == c_LAST_LANE) | w_early;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_FILL;
            r_cnt       <= '0;
            r_wait      <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_wait      <= w_wait_nxt;
            r_res_valid <= w_res_valid_nxt;
            r_res_data  <= w_res_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_wait_nxt      = r_wait;
        w_res_valid_nxt = r_res_valid;
        w_res_data_nxt  = r_res_data;
        case (r_state)
            S_FILL: begin
                if (w_xfer) begin
                    if (w_done) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_ISSUE;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                w_wait_nxt  = c_WAIT_LOAD;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (r_wait == '0) begin
                    w_res_data_nxt  = bus.mac_result;
                    w_res_valid_nxt = 1'b1;
                    w_state_nxt     = S_HOLD;
                end else begin
                    w_wait_nxt = r_wait - 1'b1;
                end
            end
            S_HOLD: begin
                if (bus.res_ready) begin
                    w_res_valid_nxt = 1'b0;
                    w_state_nxt     = S_FILL;
                end
            end
            default: w_state_nxt = S_FILL;
        endcase
    end

    // Lanes past an early-terminated vector are zeroed (+0.0) on the same edge;
    // otherwise lanes persist until overwritten by the next fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_lane <= '0;
            r_b_lane <= '0;
        end else if (w_xfer) begin
            for (int i = 0; i < N_PAIRS; i++) begin
                if (r_cnt == c_CNT_W'(i)) begin
                    r_a_lane[i] <= bus.in_a;
                    r_b_lane[i] <= bus.in_b;
                end else if (w_early && (r_cnt < c_CNT_W'(i))) begin
                    r_a_lane[i] <= '0;
                    r_b_lane[i] <= '0;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.a_vec     = r_a_lane;
    assign bus.b_vec     = r_b_lane;
    assign bus.mac_start = (r_state == S_ISSUE);
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
    assign busy          = ~((r_state == S_FILL) && (r_cnt == '0));

endmodule

`default_nettype wire

// File: tb/tb_mac_operand_feeder.sv
//==============================================================================
// Module      : tb_mac_operand_feeder
// Description : Directed self-checking bench for mac_operand_feeder with a
//               fixed-latency MAC model. Honors MAC_FEED_LAST_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mac_operand_feeder;

    localparam int N_PAIRS     = 12;
    localparam int DW          = 16;
    localparam int MAC_LATENCY = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_starts = 0;
    logic [DW-1:0]          mac_val = 16'h3c00;
    logic [MAC_LATENCY-1:0] start_sr = '0;

    logic [DW-1:0] va [N_PAIRS] = '{16'h2e66, 16'h3266, 16'h3400, 16'hb4cd, 16'h3666, 16'h3800,
                                    16'h3866, 16'h38cd, 16'hba00, 16'h3a66, 16'h3b00, 16'h3b33};
    logic [DW-1:0] vb [N_PAIRS] = '{16'h3452, 16'hbb9a, 16'h3000, 16'h3a66, 16'h3b00, 16'hba00,
                                    16'h3666, 16'h38cd, 16'h30cd, 16'h3400, 16'hb666, 16'h3866};

    mac_operand_feeder_if #(.N_PAIRS(N_PAIRS), .DW(DW)) bus ();

    mac_operand_feeder #(.N_PAIRS(N_PAIRS), .DW(DW), .MAC_LATENCY(MAC_LATENCY)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // MAC model: result valid only in the cycle MAC_LATENCY cycles after mac_start
    always @(posedge clk) start_sr <= MAC_LATENCY'({start_sr, bus.mac_start});
    always_comb bus.mac_result = start_sr[MAC_LATENCY-1] ? mac_val : 'x;

    always @(negedge clk) if (bus.mac_start === 1'b1) n_starts++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_pair(input logic [DW-1:0] a, input logic [DW-1:0] b);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
`ifdef MAC_FEED_LAST_EN
        bus.in_last  = 1'b0;
`endif
    endtask

    task automatic wait_result(input string name, input logic [DW-1:0] exp_data);
        int k;
        k = 0;
        while (bus.res_valid !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== exp_data) begin
            n_fail++;
            $display("FAIL %s: res_valid=%b res_data=%h, required 1 / %h", name, bus.res_valid, bus.res_data, exp_data);
        end
    endtask

    task automatic consume_result();
        @(negedge clk);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.res_ready = 1'b0;
`ifdef MAC_FEED_LAST_EN
        bus.in_last   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.a_vec !== '0 || bus.b_vec !== '0 || bus.mac_start !== 1'b0 || bus.res_valid !== 1'b0 ||
            bus.res_data !== '0 || busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: a_vec=%h b_vec=%h start=%b rv=%b rd=%h busy=%b rdy=%b, required all 0",
                     bus.a_vec, bus.b_vec, bus.mac_start, bus.res_valid, bus.res_data, busy, bus.in_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b busy=%b, required 1/0", bus.in_ready, busy);
        end
    endtask

    task automatic test_full_vector();
        logic [N_PAIRS*DW-1:0] exp_a, exp_b;
        int k, s0;
        s0 = n_starts;
        for (int i = 0; i < N_PAIRS; i++) begin
            exp_a[i*DW +: DW] = va[i];
            exp_b[i*DW +: DW] = vb[i];
        end
        for (int i = 0; i < N_PAIRS; i++) begin
            drive_pair(va[i], vb[i]);
            n_checks++;
            if (bus.in_ready !== 1'b1 || bus.mac_start !== 1'b0) begin
                n_fail++;
                $display("FAIL full_fill lane %0d: in_ready=%b mac_start=%b, required 1/0", i, bus.in_ready, bus.mac_start);
            end
            if (i == 1) begin
                n_checks++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL busy_partial: busy=%b, required 1", busy);
                end
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.mac_start !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL issue_pulse: mac_start=%b in_ready=%b, required 1/0", bus.mac_start, bus.in_ready);
        end
        n_checks++;
        if (bus.a_vec[15:0] !== 16'h2e66 || bus.a_vec[191:176] !== 16'h3b33 || bus.b_vec[191:176] !== 16'h3866) begin
            n_fail++;
            $display("FAIL lane_ends: a0=%h a11=%h b11=%h, required 2e66/3b33/3866",
                     bus.a_vec[15:0], bus.a_vec[191:176], bus.b_vec[191:176]);
        end
        n_checks++;
        if (bus.a_vec !== exp_a || bus.b_vec !== exp_b) begin
            n_fail++;
            $display("FAIL full_vectors: a_vec=%h b_vec=%h, required %h / %h", bus.a_vec, bus.b_vec, exp_a, exp_b);
        end
        @(negedge clk);
        k = 1;
        n_checks++;
        if (bus.mac_start !== 1'b0) begin
            n_fail++;
            $display("FAIL issue_single_cycle: mac_start=%b, required 0", bus.mac_start);
        end
        while (bus.res_valid !== 1'b1 && k < 20) begin
            if (bus.in_ready !== 1'b0) begin
                n_checks++;
                n_fail++;
                $display("FAIL wait_in_ready: in_ready=%b at edge %0d, required 0", bus.in_ready, k);
            end
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (k != MAC_LATENCY + 1 || bus.res_data !== 16'h3c00) begin
            n_fail++;
            $display("FAIL latency: res_valid after %0d edges data=%h, required %0d / 3c00", k, bus.res_data, MAC_LATENCY + 1);
        end
        n_checks++;
        if (n_starts - s0 != 1) begin
            n_fail++;
            $display("FAIL start_count_full: %0d pulses, required 1", n_starts - s0);
        end
    endtask

    task automatic test_backpressure();
        bus.in_valid = 1'b1;
        bus.in_a     = 16'h1234;
        bus.in_b     = 16'h5678;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.res_valid !== 1'b1 || bus.res_data !== 16'h3c00 || bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_stable cycle %0d: rv=%b rd=%h rdy=%b, required 1 / 3c00 / 0",
                         i, bus.res_valid, bus.res_data, bus.in_ready);
            end
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        bus.in_valid  = 1'b0;
        n_checks++;
        if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0 || bus.a_vec[15:0] !== 16'h2e66) begin
            n_fail++;
            $display("FAIL hold_release: rv=%b rdy=%b busy=%b a0=%h, required 0/1/0/2e66",
                     bus.res_valid, bus.in_ready, busy, bus.a_vec[15:0]);
        end
    endtask

    task automatic test_gapped();
        logic [N_PAIRS*DW-1:0] exp_a, exp_b;
        int s0;
        s0      = n_starts;
        mac_val = 16'hc500;
        for (int i = 0; i < N_PAIRS; i++) begin
            exp_a[i*DW +: DW] = 16'h1000 + 16'(i);
            exp_b[i*DW +: DW] = 16'h2000 + 16'(i);
        end
        for (int i = 0; i < N_PAIRS; i++) begin
            drive_pair(16'h1000 + 16'(i), 16'h2000 + 16'(i));
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_a     = 16'hdead;
            if (i < N_PAIRS - 1) begin
                n_checks++;
                if (bus.mac_start !== 1'b0) begin
                    n_fail++;
                    $display("FAIL gapped_early_start after pair %0d: mac_start=%b, required 0", i, bus.mac_start);
                end
            end
        end
        n_checks++;
        if (bus.mac_start !== 1'b1 || bus.a_vec !== exp_a || bus.b_vec !== exp_b) begin
            n_fail++;
            $display("FAIL gapped_vectors: start=%b a_vec=%h b_vec=%h, required 1 / %h / %h",
                     bus.mac_start, bus.a_vec, bus.b_vec, exp_a, exp_b);
        end
        wait_result("gapped_result", 16'hc500);
        consume_result();
        n_checks++;
        if (n_starts - s0 != 1 || bus.res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL gapped_start_count: %0d pulses rv=%b, required 1 / 0", n_starts - s0, bus.res_valid);
        end
    endtask

`ifdef MAC_FEED_LAST_EN
    task automatic test_last();
        logic [N_PAIRS*DW-1:0] exp_a, exp_b;
        exp_a = '0;
        exp_b = '0;
        mac_val = 16'h4248;
        for (int i = 0; i < 5; i++) begin
            exp_a[i*DW +: DW] = 16'h4000 + 16'(i);
            exp_b[i*DW +: DW] = 16'h5000 + 16'(i);
            drive_pair(16'h4000 + 16'(i), 16'h5000 + 16'(i));
            bus.in_last = (i == 4);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        n_checks++;
        if (bus.mac_start !== 1'b1 || bus.a_vec !== exp_a || bus.b_vec !== exp_b) begin
            n_fail++;
            $display("FAIL last_zero_fill: start=%b a_vec=%h b_vec=%h, required 1 / %h / %h",
                     bus.mac_start, bus.a_vec, bus.b_vec, exp_a, exp_b);
        end
        wait_result("last_result", 16'h4248);
        consume_result();
    endtask
`endif

    task automatic test_reset_mid_wait();
        int s0;
        for (int i = 0; i < N_PAIRS; i++) drive_pair(va[i], vb[i]);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.a_vec !== '0 || bus.b_vec !== '0 || bus.res_valid !== 1'b0 || bus.res_data !== '0 ||
            bus.mac_start !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: a=%h b=%h rv=%b rd=%h start=%b busy=%b rdy=%b, required all 0",
                     bus.a_vec, bus.b_vec, bus.res_valid, bus.res_data, bus.mac_start, busy, bus.in_ready);
        end
        s0 = n_starts;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.res_valid !== 1'b0) begin
                n_checks++;
                n_fail++;
                $display("FAIL reset_no_result cycle %0d: res_valid=%b, required 0", i, bus.res_valid);
            end
        end
        n_checks++;
        if (n_starts != s0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_recover: extra starts=%0d rdy=%b busy=%b, required 0/1/0", n_starts - s0, bus.in_ready, busy);
        end
    endtask

    initial begin
        test_reset();
        test_full_vector();
        test_backpressure();
        test_gapped();
`ifdef MAC_FEED_LAST_EN
        test_last();
`endif
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
